// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared types for the IF/D memory port arbiter
package mem_port_arbiter_pkg;

    localparam int RV_XLEN = 32;

    typedef logic [RV_XLEN-1:0] rvwordT;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } ArbStateT;

    typedef enum logic {
        OWN_IF,
        OWN_D
    } ArbOwnerT;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester, memory and status bundle for the arbiter
// slave is the arbiter's view; master is the surrounding fetch/execute/memory view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req_valid;
    logic                  if_req_ready;
    logic [ADDR_W-1:0]     if_req_addr;
    logic                  if_resp_valid;
    logic [DATA_W-1:0]     if_resp_data;

    logic                  d_req_valid;
    logic                  d_req_ready;
    logic                  d_req_write;
    logic [ADDR_W-1:0]     d_req_addr;
    logic [DATA_W-1:0]     d_req_wdata;
    logic [DATA_W/8-1:0]   d_req_be;
    logic                  d_resp_valid;
    logic [DATA_W-1:0]     d_resp_data;

    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic                  mem_req_write;
    logic [ADDR_W-1:0]     mem_req_addr;
    logic [DATA_W-1:0]     mem_req_wdata;
    logic [DATA_W/8-1:0]   mem_req_be;
    logic                  mem_resp_valid;
    logic [DATA_W-1:0]     mem_resp_data;

    logic                  err_stray;

    modport slave (
        input  if_req_valid, if_req_addr,
        output if_req_ready, if_resp_valid, if_resp_data,
        input  d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_be,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be,
        input  mem_req_ready, mem_resp_valid, mem_resp_data,
        output err_stray
    );

    modport master (
        output if_req_valid, if_req_addr,
        input  if_req_ready, if_resp_valid, if_resp_data,
        output d_req_valid, d_req_write, d_req_addr, d_req_wdata, d_req_be,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata, mem_req_be,
        output mem_req_ready, mem_resp_valid, mem_resp_data,
        input  err_stray
    );
endinterface

// File: rtl/mem_port_arbiter_select.sv
// rtl/mem_port_arbiter_select.sv - D-priority winner select with IF starvation counter
module mem_arb_select #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic if_valid_i,
    input  logic d_valid_i,
    input  logic grant_en_i,
    output logic if_win_o,
    output logic d_win_o
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] starve_q, starve_d;
    logic             at_limit;

    assign at_limit = (starve_q == CNT_W'(STARVE_LIMIT));
    assign if_win_o = if_valid_i && (!d_valid_i || at_limit);
    assign d_win_o  = d_valid_i && !if_win_o;

    // The count only measures D grants that happen while IF is actually waiting.
    always_comb begin
        starve_d = starve_q;
        if (!if_valid_i) begin
            starve_d = '0;
        end else if (grant_en_i && if_win_o) begin
            starve_d = '0;
        end else if (grant_en_i && d_win_o && !at_limit) begin
            starve_d = starve_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single-outstanding arbiter sharing one memory port between IF and D
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    mem_port_arbiter_if.slave bus
);
    localparam int BE_W = DATA_W / 8;

    ArbStateT            state_q;
    ArbOwnerT            owner_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic                write_q;
    logic                mem_req_valid_q;
    logic                if_resp_valid_q;
    logic                d_resp_valid_q;
    logic [DATA_W-1:0]   if_resp_data_q;
    logic [DATA_W-1:0]   d_resp_data_q;
    logic                err_stray_q;

    logic                idle;
    logic                if_win;
    logic                d_win;

    assign idle = (state_q == ARB_IDLE);

    mem_arb_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk        (clk),
        .rst        (rst),
        .if_valid_i (bus.if_req_valid),
        .d_valid_i  (bus.d_req_valid),
        .grant_en_i (idle),
        .if_win_o   (if_win),
        .d_win_o    (d_win)
    );

    assign bus.if_req_ready  = idle && if_win;
    assign bus.d_req_ready   = idle && d_win;
    assign bus.if_resp_valid = if_resp_valid_q;
    assign bus.if_resp_data  = if_resp_data_q;
    assign bus.d_resp_valid  = d_resp_valid_q;
    assign bus.d_resp_data   = d_resp_data_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_req_write = write_q;
    assign bus.mem_req_addr  = addr_q;
    assign bus.mem_req_wdata = wdata_q;
    assign bus.mem_req_be    = be_q;
    assign bus.err_stray     = err_stray_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ARB_IDLE;
            owner_q         <= OWN_IF;
            addr_q          <= '0;
            wdata_q         <= '0;
            be_q            <= '0;
            write_q         <= 1'b0;
            mem_req_valid_q <= 1'b0;
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            if_resp_data_q  <= '0;
            d_resp_data_q   <= '0;
            err_stray_q     <= 1'b0;
        end else begin
            if_resp_valid_q <= 1'b0;
            d_resp_valid_q  <= 1'b0;
            // Any read data arriving with nothing outstanding is a memory-side protocol error.
            if (bus.mem_resp_valid && (state_q != ARB_WAIT)) begin
                err_stray_q <= 1'b1;
            end
            case (state_q)
                ARB_IDLE: begin
                    if (if_win) begin
                        owner_q         <= OWN_IF;
                        addr_q          <= bus.if_req_addr;
                        wdata_q         <= '0;
                        be_q            <= '1;
                        write_q         <= 1'b0;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ARB_ISSUE;
                    end else if (d_win) begin
                        owner_q         <= OWN_D;
                        addr_q          <= bus.d_req_addr;
                        wdata_q         <= bus.d_req_wdata;
                        be_q            <= bus.d_req_write ? bus.d_req_be : '1;
                        write_q         <= bus.d_req_write;
                        mem_req_valid_q <= 1'b1;
                        state_q         <= ARB_ISSUE;
                    end
                end
                ARB_ISSUE: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        if (write_q) begin
                            d_resp_valid_q <= 1'b1;
                            d_resp_data_q  <= '0;
                            state_q        <= ARB_IDLE;
                        end else begin
                            state_q        <= ARB_WAIT;
                        end
                    end
                end
                ARB_WAIT: begin
                    if (bus.mem_resp_valid) begin
                        if (owner_q == OWN_IF) begin
                            if_resp_valid_q <= 1'b1;
                            if_resp_data_q  <= bus.mem_resp_data;
                        end else begin
                            d_resp_valid_q  <= 1'b1;
                            d_resp_data_q   <= bus.mem_resp_data;
                        end
                        state_q <= ARB_IDLE;
                    end
                end
                default: state_q <= ARB_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int STARVE = 4;

    typedef struct {
        bit         is_d;
        bit         wr;
        rvwordT     addr;
        rvwordT     wdata;
        logic [3:0] be;
        int         stall;
        int         lat;
        rvwordT     exp_data;
        int         exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) mif ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(STARVE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (mif.slave)
    );

    int checks = 0;
    int failures = 0;

    rvwordT ram  [rvwordT];
    rvwordT gold [rvwordT];
    rvwordT exp_if[$];
    rvwordT exp_d[$];

    int mem_stall = 0;
    int mem_lat = 0;
    int wr_seen = 0;
    int rd_seen = 0;
    bit inject_stray = 0;

    bit         s_if_acc, s_d_acc, s_if_rsp, s_d_rsp, s_if_rdy, s_d_rdy;
    bit         s_mem_valid, s_mem_write, s_err;
    rvwordT     s_if_data, s_d_data, s_mem_addr;
    logic [3:0] s_mem_be;

    task automatic check_eq(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic rvwordT merge(input rvwordT old, input rvwordT wd, input logic [3:0] be);
        rvwordT r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    function automatic rvwordT ram_rd(input rvwordT a);
        return ram.exists(a) ? ram[a] : ~a;
    endfunction

    function automatic rvwordT gold_rd(input rvwordT a);
        return gold.exists(a) ? gold[a] : ~a;
    endfunction

    // Memory model: programmable request stall and read latency, plus stray-pulse injection.
    int     stall_cnt = 0;
    bit     pend = 0;
    int     pend_cnt = 0;
    rvwordT pend_data;
    initial begin
        mif.mem_req_ready  = 1'b0;
        mif.mem_resp_valid = 1'b0;
        mif.mem_resp_data  = '0;
        forever begin
            @(posedge clk); #1;
            mif.mem_req_ready  = 1'b0;
            mif.mem_resp_valid = 1'b0;
            if (pend) begin
                if (pend_cnt == 0) begin
                    mif.mem_resp_valid = 1'b1;
                    mif.mem_resp_data  = pend_data;
                    pend = 0;
                end else begin
                    pend_cnt--;
                end
            end else if (inject_stray) begin
                mif.mem_resp_valid = 1'b1;
                mif.mem_resp_data  = 32'hBAD0BAD0;
                inject_stray = 0;
            end
            if (mif.mem_req_valid) begin
                if (stall_cnt < mem_stall) begin
                    stall_cnt++;
                end else begin
                    mif.mem_req_ready = 1'b1;
                    stall_cnt = 0;
                    if (mif.mem_req_write) begin
                        wr_seen++;
                        ram[mif.mem_req_addr] = merge(ram_rd(mif.mem_req_addr), mif.mem_req_wdata, mif.mem_req_be);
                    end else begin
                        rd_seen++;
                        pend      = 1;
                        pend_cnt  = mem_lat;
                        pend_data = ram_rd(mif.mem_req_addr);
                    end
                end
            end
        end
    end

    // Scoreboard: requests are served in acceptance order, so expected data is fixed at accept time.
    int     starve_run = 0;
    rvwordT mon_e;
    initial forever begin
        @(negedge clk);
        if (rst) begin
            exp_if.delete();
            exp_d.delete();
            starve_run = 0;
        end else begin
            check_eq("resp_exclusive", mif.if_resp_valid && mif.d_resp_valid, 0);
            check_eq("ready_exclusive", mif.if_req_ready && mif.d_req_ready, 0);
            if (mif.if_resp_valid) begin
                check_eq("if_resp_expected", exp_if.size() != 0, 1);
                if (exp_if.size() != 0) begin
                    mon_e = exp_if.pop_front();
                    check_eq("if_resp_data", mif.if_resp_data, mon_e);
                end
            end
            if (mif.d_resp_valid) begin
                check_eq("d_resp_expected", exp_d.size() != 0, 1);
                if (exp_d.size() != 0) begin
                    mon_e = exp_d.pop_front();
                    check_eq("d_resp_data", mif.d_resp_data, mon_e);
                end
            end
            if (mif.if_req_valid && mif.if_req_ready)
                exp_if.push_back(gold_rd(mif.if_req_addr));
            if (mif.d_req_valid && mif.d_req_ready) begin
                if (mif.if_req_valid) starve_run++;
                check_eq("starve_bound", starve_run <= STARVE, 1);
                if (mif.d_req_write) begin
                    gold[mif.d_req_addr] = merge(gold_rd(mif.d_req_addr), mif.d_req_wdata, mif.d_req_be);
                    exp_d.push_back('0);
                end else begin
                    exp_d.push_back(gold_rd(mif.d_req_addr));
                end
            end
            if (!mif.if_req_valid || mif.if_req_ready) starve_run = 0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
        s_if_acc    = mif.if_req_valid && mif.if_req_ready;
        s_d_acc     = mif.d_req_valid && mif.d_req_ready;
        s_if_rdy    = mif.if_req_ready;
        s_d_rdy     = mif.d_req_ready;
        s_if_rsp    = mif.if_resp_valid;
        s_d_rsp     = mif.d_resp_valid;
        s_if_data   = mif.if_resp_data;
        s_d_data    = mif.d_resp_data;
        s_mem_valid = mif.mem_req_valid;
        s_mem_write = mif.mem_req_write;
        s_mem_addr  = mif.mem_req_addr;
        s_mem_be    = mif.mem_req_be;
        s_err       = mif.err_stray;
        @(posedge clk); #1;
        if (s_if_acc) mif.if_req_valid = 1'b0;
        if (s_d_acc)  mif.d_req_valid  = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((mif.if_req_valid || mif.d_req_valid || exp_if.size() != 0 || exp_d.size() != 0) && t < 500) begin
            tick();
            t++;
        end
        check_eq("drain_done", t < 500, 1);
        tick();
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        int t;
        bit got;
        int wr0;
        mem_stall = v.stall;
        mem_lat   = v.lat;
        wr0       = wr_seen;
        if (v.is_d) begin
            mif.d_req_write = v.wr;
            mif.d_req_addr  = v.addr;
            mif.d_req_wdata = v.wdata;
            mif.d_req_be    = v.be;
            mif.d_req_valid = 1'b1;
        end else begin
            mif.if_req_addr  = v.addr;
            mif.if_req_valid = 1'b1;
        end
        t = 0; got = 0;
        while (!got && t < 20) begin
            tick();
            got = v.is_d ? s_d_acc : s_if_acc;
            t++;
        end
        check_eq({tag, "_accept"}, got, 1);
        t = 0; got = 0;
        while (!got && t < 40) begin
            tick();
            t++;
            got = v.is_d ? s_d_rsp : s_if_rsp;
        end
        check_eq({tag, "_resp_seen"}, got, 1);
        check_eq({tag, "_latency"}, t, v.exp_lat);
        check_eq({tag, "_data"}, v.is_d ? s_d_data : s_if_data, v.exp_data);
        check_eq({tag, "_mem_writes"}, wr_seen - wr0, v.wr);
    endtask

    vec_t vecs[9];
    bit   exp_order[10];
    bit   order[10];

    initial begin
        int n, t, cnt;
        vecs[0] = '{1'b0, 1'b0, 32'h100, 32'h0,        4'hF, 0, 0, 32'hDEADBEEF, 3};
        vecs[1] = '{1'b1, 1'b1, 32'h200, 32'h12345678, 4'hF, 0, 0, 32'h0,        2};
        vecs[2] = '{1'b1, 1'b0, 32'h200, 32'h0,        4'hF, 0, 0, 32'h12345678, 3};
        vecs[3] = '{1'b1, 1'b1, 32'h200, 32'hAABBCCDD, 4'h5, 2, 0, 32'h0,        4};
        vecs[4] = '{1'b0, 1'b0, 32'h200, 32'h0,        4'hF, 1, 2, 32'h12BB56DD, 6};
        vecs[5] = '{1'b1, 1'b0, 32'h300, 32'h0,        4'hF, 0, 0, 32'hFFFFFCFF, 3};
        vecs[6] = '{1'b0, 1'b0, 32'h104, 32'h0,        4'hF, 0, 1, 32'hCAFEF00D, 4};
        vecs[7] = '{1'b1, 1'b1, 32'h104, 32'hFFFFFFFF, 4'h0, 0, 0, 32'h0,        2};
        vecs[8] = '{1'b0, 1'b0, 32'h104, 32'h0,        4'hF, 0, 0, 32'hCAFEF00D, 3};
        exp_order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
        ram[32'h100] = 32'hDEADBEEF;  gold[32'h100] = 32'hDEADBEEF;
        ram[32'h104] = 32'hCAFEF00D;  gold[32'h104] = 32'hCAFEF00D;

        mif.if_req_valid = 1'b0; mif.if_req_addr = '0;
        mif.d_req_valid  = 1'b0; mif.d_req_write = 1'b0;
        mif.d_req_addr   = '0;   mif.d_req_wdata = '0; mif.d_req_be = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_mem_req_valid", mif.mem_req_valid, 0);
        check_eq("rst_mem_req_addr", mif.mem_req_addr, 0);
        check_eq("rst_if_resp_valid", mif.if_resp_valid, 0);
        check_eq("rst_d_resp_valid", mif.d_resp_valid, 0);
        check_eq("rst_if_resp_data", mif.if_resp_data, 0);
        check_eq("rst_d_resp_data", mif.d_resp_data, 0);
        check_eq("rst_err_stray", mif.err_stray, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

        // Both requesters continuously valid: expect four D grants then one forced IF grant.
        mem_stall = 0; mem_lat = 0;
        mif.if_req_addr = 32'h100;
        mif.d_req_write = 1'b0; mif.d_req_addr = 32'h204;
        mif.if_req_valid = 1'b1; mif.d_req_valid = 1'b1;
        n = 0; t = 0;
        while (n < 10 && t < 300) begin
            tick();
            t++;
            if (s_d_acc) begin order[n] = 1; n++; end
            else if (s_if_acc) begin order[n] = 0; n++; end
            mif.if_req_valid = (n < 10);
            mif.d_req_valid  = (n < 10);
        end
        check_eq("starve_grant_count", n, 10);
        for (int i = 0; i < 10; i++) check_eq($sformatf("starve_grant%0d_is_d", i), order[i], exp_order[i]);
        drain();

        // Memory holds off the request: fields must stay put and nobody else gets in.
        mem_stall = 5;
        mif.d_req_write = 1'b0; mif.d_req_addr = 32'h600; mif.d_req_be = 4'h3;
        mif.d_req_valid = 1'b1;
        t = 0;
        do begin tick(); t++; end while (!s_d_acc && t < 20);
        check_eq("stall_accept", s_d_acc, 1);
        mif.if_req_addr = 32'h100; mif.if_req_valid = 1'b1;
        mif.d_req_addr  = 32'h604; mif.d_req_valid  = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall_mem_valid", s_mem_valid, 1);
            check_eq("stall_mem_addr", s_mem_addr, 32'h600);
            check_eq("stall_mem_write", s_mem_write, 0);
            check_eq("stall_mem_be", s_mem_be, 4'hF);
            check_eq("stall_if_ready", s_if_rdy, 0);
            check_eq("stall_d_ready", s_d_rdy, 0);
        end
        mem_stall = 0;
        drain();

        // Randomized traffic against the scoreboard.
        for (int c = 0; c < 600; c++) begin
            mem_stall = $urandom_range(0, 2);
            mem_lat   = $urandom_range(0, 2);
            if (!mif.if_req_valid && $urandom_range(0, 2) == 0) begin
                mif.if_req_addr  = 32'h800 + 4 * $urandom_range(0, 7);
                mif.if_req_valid = 1'b1;
            end
            if (!mif.d_req_valid && $urandom_range(0, 1) == 0) begin
                mif.d_req_write = $urandom_range(0, 1);
                mif.d_req_addr  = 32'h800 + 4 * $urandom_range(0, 7);
                mif.d_req_wdata = $urandom;
                mif.d_req_be    = 4'($urandom_range(0, 15));
                mif.d_req_valid = 1'b1;
            end
            tick();
        end
        mem_stall = 0; mem_lat = 0;
        drain();

        check_eq("err_clean_before_stray", s_err, 0);
        inject_stray = 1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            cnt += s_if_rsp + s_d_rsp;
        end
        check_eq("stray_err_set", s_err, 1);
        check_eq("stray_no_resp", cnt, 0);

        // Reset while a read is in WAIT; the late response must be dropped and flagged.
        mem_lat = 4;
        mif.d_req_write = 1'b0; mif.d_req_addr = 32'h200; mif.d_req_valid = 1'b1;
        n = rd_seen; t = 0;
        while (rd_seen == n && t < 20) begin tick(); t++; end
        check_eq("rstwait_mem_read", rd_seen - n, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check_eq("rstwait_err_cleared", s_err, 0);
        cnt = s_if_rsp + s_d_rsp;
        for (int i = 0; i < 6; i++) begin
            tick();
            cnt += s_if_rsp + s_d_rsp;
        end
        check_eq("rstwait_no_resp", cnt, 0);
        check_eq("rstwait_err_set", s_err, 1);
        mem_lat = 0;
        apply_vec(vecs[0], "after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
